potential_mem: RTL and testbench
================================

POTENTIAL_MEM -- requirements
Module: potential_mem

Interface
REQ-001 SHALL have parameter NEURONS, default 64, number of neuron potential entries.
REQ-002 SHALL have parameter ADDR_W, default 6, address width (2^ADDR_W >= NEURONS).
REQ-003 SHALL have parameter V_REST, default 32'hC2820000 (-65.0 IEEE-754 single), resting potential.
REQ-004 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-006 SHALL have port wr_en  input  1  write request from the spike-reset stage.
REQ-007 SHALL have port wr_addr  input  ADDR_W  neuron index to write.
REQ-008 SHALL have port potential_to_mem  input  32  float32 potential produced by the reset stage.
REQ-009 SHALL have port spiked  input  1  spike flag accompanying the write.
REQ-010 SHALL have port rd_en  input  1  read request from the potential-adder stage.
REQ-011 SHALL have port rd_addr  input  ADDR_W  neuron index to read.
REQ-012 SHALL have port rd_valid  output  1  read data valid.
REQ-013 SHALL have port rd_potential  output  32  stored float32 potential.
REQ-014 SHALL have port rd_spiked  output  1  stored spike flag.
REQ-015 SHALL have port clear  input  1  request a full re-initialisation to V_REST.
REQ-016 SHALL have port busy  output  1  high while clearing; requests ignored.

Function
REQ-017 SHALL store per neuron one 32-bit potential and one spike bit; the potential is stored bit-exact, with no arithmetic.
REQ-018 SHALL implement FSM states CLEAR and IDLE; RESET forces CLEAR with clear counter 0.
REQ-019 In CLEAR, each cycle: entry[cnt] <= {V_REST, spike=0} and cnt++; at cnt==NEURONS-1 that write occurs and the next state is IDLE.
REQ-020 The clear sequence SHALL last exactly NEURONS cycles; busy=1 during every CLEAR cycle and 0 in IDLE.
REQ-021 In IDLE, clear=1 SHALL enter CLEAR next cycle with cnt=0; a wr_en in the same cycle is dropped, and clear wins.
REQ-022 clear while busy SHALL be ignored; the sequence is not restarted.
REQ-023 In IDLE, wr_en=1 SHALL write potential_to_mem and spiked to entry[wr_addr] at the clock edge.
REQ-024 Read latency SHALL be 1 cycle: rd_en=1 at edge N gives rd_valid=1 with data after edge N; rd_valid=0 otherwise.
REQ-025 A same-cycle read and write to the same address SHALL return the newly written data (write-first forwarding).
REQ-026 rd_en or wr_en while busy SHALL be ignored: no write, and rd_valid=0 next cycle.
REQ-027 wr_addr or rd_addr >= NEURONS SHALL be ignored for writes; such reads return rd_valid=1 with V_REST and spike 0.
REQ-028 rd_potential and rd_spiked SHALL hold their last value when rd_valid=0.

Reset
REQ-029 On RESET=1 at an edge: state=CLEAR, cnt=0, rd_valid=0, rd_potential=0, rd_spiked=0, busy=1.
REQ-030 RESET asserted mid-clear or mid-operation SHALL restart the clear at address 0; in-flight requests are discarded.
REQ-031 Storage contents SHALL NOT be relied on until the first clear completes.

Structure
REQ-032 FSM state encoding, V_REST default and float32 width constant SHALL live in shared package neuron_pkg.
REQ-033 Storage SHALL be a sub-module potential_ram with a synchronous write and a registered read; the FSM, forwarding and range checks sit in potential_mem.

Verification
REQ-034 The bench SHALL check reset behaviour: RESET 1 cycle, then idle -> busy=1 for exactly 64 cycles; afterwards reading addr 0, 31 and 63 returns 32'hC2820000, spike 0.
REQ-035 The bench SHALL check write then read: write addr 5 = 32'h40A00000 (5.0) with spiked=1; next cycle read addr 5 -> rd_valid=1, 32'h40A00000, rd_spiked=1.
REQ-036 The bench SHALL check forwarding: same cycle write addr 9 = 32'h3F800000 and read addr 9 -> next cycle rd_potential=32'h3F800000.
REQ-037 The bench SHALL check clear versus write: clear and wr_en addr 3 = 32'h41200000 in the same cycle -> after 64 busy cycles, addr 3 reads 32'hC2820000.
REQ-038 The bench SHALL check busy gating: rd_en and wr_en addr 7 during CLEAR -> rd_valid stays 0 and addr 7 = V_REST afterwards.
REQ-039 The bench SHALL check reset mid-clear: RESET at clear cycle 20 -> busy for 64 further cycles, and all entries read V_REST.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and constants for the neuron datapath: float32 width, resting
// potential, potential-memory FSM encoding and the stored entry layout.
package neuron_pkg;

   localparam int unsigned FP32_W = 32;
   localparam logic [FP32_W-1:0] V_REST_DEFAULT = 32'hC2820000;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } mem_state_t;

   // Which registered source drives the read data outputs.
   typedef enum logic [1:0] {
      SRC_RAM  = 2'd0,
      SRC_FWD  = 2'd1,
      SRC_REST = 2'd2
   } rd_src_t;

   typedef struct packed {
      logic [FP32_W-1:0] potential;
      logic              spiked;
   } pot_entry_t;

endpackage

// File: rtl/potential_ram.sv
// Per-neuron storage: synchronous write, registered read that holds its value
// when no read is requested.
module potential_ram
   import neuron_pkg::*;
#(
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned ADDR_W = 6
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  pot_entry_t        wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output pot_entry_t        rdata
);

   pot_entry_t mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read register is cleared by reset so the top's outputs start at zero.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/potential_mem.sv
// Neuron potential memory: clear-to-rest sequencer, range checks and
// write-first forwarding around a registered-read RAM.
module potential_mem
   import neuron_pkg::*;
#(
   parameter int unsigned       NEURONS = 64,
   parameter int unsigned       ADDR_W  = 6,
   parameter logic [FP32_W-1:0] V_REST  = V_REST_DEFAULT
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [FP32_W-1:0] potential_to_mem,
   input  logic              spiked,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid,
   output logic [FP32_W-1:0] rd_potential,
   output logic              rd_spiked,
   input  logic              clear,
   output logic              busy
);

   localparam pot_entry_t        REST_ENTRY = '{potential: V_REST, spiked: 1'b0};
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NEURONS - 1);

   mem_state_t        state;
   logic [ADDR_W-1:0] cnt;
   rd_src_t           rd_src;
   pot_entry_t        fwd_entry;

   pot_entry_t        wr_entry;
   pot_entry_t        ram_rdata;
   pot_entry_t        ram_wdata;
   logic [ADDR_W-1:0] ram_waddr;
   logic              ram_we;
   logic              ram_re;
   logic              wr_ok;
   logic              rd_ok;
   logic              wr_take;
   logic              fwd_hit;

   // Request qualification: range, clear priority, same-address forwarding.
   always_comb begin
      wr_entry = '{potential: potential_to_mem, spiked: spiked};
      wr_ok    = 32'(wr_addr) < NEURONS;
      rd_ok    = 32'(rd_addr) < NEURONS;
      wr_take  = (state == ST_IDLE) && wr_en && !clear && wr_ok;
      fwd_hit  = wr_take && (wr_addr == rd_addr);
   end

   // RAM port control: the clear sequencer owns the write port while busy.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = wr_addr;
      ram_wdata = wr_entry;
      ram_re    = 1'b0;
      if (!RESET) begin
         if (state == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = cnt;
            ram_wdata = REST_ENTRY;
         end else begin
            ram_we = wr_take;
            ram_re = rd_en && rd_ok && !fwd_hit;
         end
      end
   end

   potential_ram #(
      .DEPTH  (NEURONS),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .CLK   (CLK),
      .RESET (RESET),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .re    (ram_re),
      .raddr (rd_addr),
      .rdata (ram_rdata)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= ST_CLEAR;
         cnt       <= '0;
         busy      <= 1'b1;
         rd_valid  <= 1'b0;
         rd_src    <= SRC_RAM;
         fwd_entry <= '0;
      end else begin
         case (state)
            ST_CLEAR: begin
               rd_valid <= 1'b0;
               if (cnt == LAST_ADDR) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + ADDR_W'(1);
               end
            end
            ST_IDLE: begin
               rd_valid <= rd_en;
               if (rd_en) begin
                  if (!rd_ok) begin
                     rd_src <= SRC_REST;
                  end else if (fwd_hit) begin
                     rd_src    <= SRC_FWD;
                     fwd_entry <= wr_entry;
                  end else begin
                     rd_src <= SRC_RAM;
                  end
               end
               if (clear) begin
                  state <= ST_CLEAR;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            default: begin
               state <= ST_CLEAR;
               cnt   <= '0;
               busy  <= 1'b1;
            end
         endcase
      end
   end

   // Output select over registered sources; every source holds when idle.
   always_comb begin
      rd_potential = ram_rdata.potential;
      rd_spiked    = ram_rdata.spiked;
      case (rd_src)
         SRC_FWD: begin
            rd_potential = fwd_entry.potential;
            rd_spiked    = fwd_entry.spiked;
         end
         SRC_REST: begin
            rd_potential = REST_ENTRY.potential;
            rd_spiked    = REST_ENTRY.spiked;
         end
         default: begin
            rd_potential = ram_rdata.potential;
            rd_spiked    = ram_rdata.spiked;
         end
      endcase
   end

endmodule

// File: tb/tb_potential_mem.sv
// Directed bench for potential_mem: vector table for idle read/write traffic,
// hand sequences for reset, clear, busy gating and out-of-range addresses.
module tb_potential_mem;

   localparam logic [31:0] VR = 32'hC2820000;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        wr_en;
   logic [5:0]  wr_addr;
   logic [31:0] potential_to_mem;
   logic        spiked;
   logic        rd_en;
   logic [5:0]  rd_addr;
   logic        clear;
   logic        rd_valid, rd_spiked, busy;
   logic [31:0] rd_potential;
   logic        s_rd_valid, s_rd_spiked, s_busy;
   logic [31:0] s_rd_potential;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 CLK = ~CLK;

   potential_mem dut (
      .CLK(CLK), .RESET(RESET), .wr_en(wr_en), .wr_addr(wr_addr),
      .potential_to_mem(potential_to_mem), .spiked(spiked), .rd_en(rd_en),
      .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_potential(rd_potential),
      .rd_spiked(rd_spiked), .clear(clear), .busy(busy)
   );

   // Smaller instance sharing the inputs, so addresses 48..63 are out of range.
   potential_mem #(.NEURONS(48), .ADDR_W(6)) dut_small (
      .CLK(CLK), .RESET(RESET), .wr_en(wr_en), .wr_addr(wr_addr),
      .potential_to_mem(potential_to_mem), .spiked(spiked), .rd_en(rd_en),
      .rd_addr(rd_addr), .rd_valid(s_rd_valid), .rd_potential(s_rd_potential),
      .rd_spiked(s_rd_spiked), .clear(clear), .busy(s_busy)
   );

   typedef struct {
      logic        wr_en;
      logic [5:0]  wr_addr;
      logic [31:0] wdata;
      logic        spk;
      logic        rd_en;
      logic [5:0]  rd_addr;
      logic        exp_valid;
      logic [31:0] exp_pot;
      logic        exp_spk;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      wr_en = 0; wr_addr = 0; potential_to_mem = 0; spiked = 0;
      rd_en = 0; rd_addr = 0; clear = 0;
   endtask

   task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic s);
      wr_en = 1; wr_addr = a; potential_to_mem = d; spiked = s;
      step();
      wr_en = 0;
   endtask

   task automatic do_read(input string name, input logic [5:0] a,
                          input logic [31:0] exp_pot, input logic exp_spk);
      rd_en = 1; rd_addr = a;
      step();
      rd_en = 0;
      check({name, "_valid"}, 32'(rd_valid), 32'd1);
      check({name, "_pot"}, rd_potential, exp_pot);
      check({name, "_spk"}, 32'(rd_spiked), 32'(exp_spk));
   endtask

   // Counts busy cycles from the current sample point until busy drops.
   task automatic count_busy(output int n);
      n = 0;
      while (busy && n < 200) begin
         n++;
         step();
      end
   endtask

   initial begin
      int n;
      int n_small;
      int gate_bad;

      vecs[0]  = '{0, 6'd0,  32'h0,        0, 1, 6'd0,  1, VR,           0};
      vecs[1]  = '{0, 6'd0,  32'h0,        0, 1, 6'd31, 1, VR,           0};
      vecs[2]  = '{0, 6'd0,  32'h0,        0, 1, 6'd63, 1, VR,           0};
      vecs[3]  = '{1, 6'd5,  32'h40A00000, 1, 0, 6'd0,  0, VR,           0};
      vecs[4]  = '{0, 6'd0,  32'h0,        0, 1, 6'd5,  1, 32'h40A00000, 1};
      vecs[5]  = '{1, 6'd9,  32'h3F800000, 0, 1, 6'd9,  1, 32'h3F800000, 0};
      vecs[6]  = '{0, 6'd0,  32'h0,        0, 0, 6'd0,  0, 32'h3F800000, 0};
      vecs[7]  = '{1, 6'd10, 32'h41200000, 1, 1, 6'd5,  1, 32'h40A00000, 1};
      vecs[8]  = '{0, 6'd0,  32'h0,        0, 1, 6'd10, 1, 32'h41200000, 1};
      vecs[9]  = '{0, 6'd0,  32'h0,        0, 1, 6'd9,  1, 32'h3F800000, 0};
      vecs[10] = '{1, 6'd5,  32'hC1200000, 0, 1, 6'd5,  1, 32'hC1200000, 0};
      vecs[11] = '{1, 6'd63, 32'h7F800000, 1, 1, 6'd63, 1, 32'h7F800000, 1};
      vecs[12] = '{0, 6'd0,  32'h0,        0, 1, 6'd4,  1, VR,           0};

      idle_inputs();
      RESET = 1;
      step();
      check("reset_busy", 32'(busy), 32'd1);
      check("reset_rd_valid", 32'(rd_valid), 32'd0);
      check("reset_rd_pot", rd_potential, 32'd0);
      check("reset_rd_spk", 32'(rd_spiked), 32'd0);
      RESET = 0;

      // Initial clear: both instances, 64 and 48 busy cycles respectively.
      n = 0;
      n_small = 0;
      while (busy && n < 200) begin
         n++;
         if (s_busy) n_small++;
         step();
      end
      check("init_busy_cycles", 32'(n), 32'd64);
      check("init_small_busy_cycles", 32'(n_small), 32'd48);

      foreach (vecs[i]) begin
         wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr;
         potential_to_mem = vecs[i].wdata; spiked = vecs[i].spk;
         rd_en = vecs[i].rd_en; rd_addr = vecs[i].rd_addr;
         step();
         check($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(vecs[i].exp_valid));
         check($sformatf("vec%0d_pot", i), rd_potential, vecs[i].exp_pot);
         check($sformatf("vec%0d_spk", i), 32'(rd_spiked), 32'(vecs[i].exp_spk));
      end
      idle_inputs();

      // Clear and a write in the same cycle: clear wins, write is dropped.
      clear = 1; wr_en = 1; wr_addr = 6'd3; potential_to_mem = 32'h41200000; spiked = 1;
      step();
      idle_inputs();
      count_busy(n);
      check("clr_vs_wr_busy_cycles", 32'(n), 32'd64);
      do_read("clr_vs_wr_a3", 6'd3, VR, 0);
      do_read("clr_vs_wr_a10", 6'd10, VR, 0);

      // Requests and a repeated clear during busy are all ignored.
      clear = 1;
      step();
      wr_en = 1; wr_addr = 6'd7; potential_to_mem = 32'h12345678; spiked = 1;
      rd_en = 1; rd_addr = 6'd7; clear = 1;
      n = 0;
      gate_bad = 0;
      while (busy && n < 200) begin
         n++;
         if (rd_valid !== 1'b0) gate_bad++;
         step();
      end
      idle_inputs();
      check("gate_busy_cycles", 32'(n), 32'd64);
      check("gate_rd_valid_during_busy", 32'(gate_bad), 32'd0);
      check("gate_rd_valid_after", 32'(rd_valid), 32'd0);
      do_read("gate_a7", 6'd7, VR, 0);

      // Reset in the middle of a clear restarts the full sequence.
      do_write(6'd40, 32'h40A00000, 1);
      do_write(6'd60, 32'h41200000, 1);
      do_read("pre_rst_a40", 6'd40, 32'h40A00000, 1);
      clear = 1;
      step();
      clear = 0;
      for (int k = 0; k < 20; k++) step();
      RESET = 1;
      step();
      RESET = 0;
      check("midrst_busy", 32'(busy), 32'd1);
      check("midrst_rd_valid", 32'(rd_valid), 32'd0);
      check("midrst_rd_pot", rd_potential, 32'd0);
      check("midrst_rd_spk", 32'(rd_spiked), 32'd0);
      count_busy(n);
      check("midrst_busy_cycles", 32'(n), 32'd64);
      for (int a = 0; a < 64; a++) begin
         do_read($sformatf("midrst_a%0d", a), 6'(a), VR, 0);
      end

      // Out-of-range handling on the 48-entry instance.
      wr_en = 1; wr_addr = 6'd50; potential_to_mem = 32'h40A00000; spiked = 1;
      rd_en = 1; rd_addr = 6'd50;
      step();
      idle_inputs();
      check("oor_fwd_small_valid", 32'(s_rd_valid), 32'd1);
      check("oor_fwd_small_pot", s_rd_potential, VR);
      check("oor_fwd_small_spk", 32'(s_rd_spiked), 32'd0);
      check("oor_fwd_big_pot", rd_potential, 32'h40A00000);
      rd_en = 1; rd_addr = 6'd50;
      step();
      idle_inputs();
      check("oor_rd_small_valid", 32'(s_rd_valid), 32'd1);
      check("oor_rd_small_pot", s_rd_potential, VR);
      check("oor_rd_small_spk", 32'(s_rd_spiked), 32'd0);
      check("oor_rd_big_pot", rd_potential, 32'h40A00000);
      do_write(6'd2, 32'h3F800000, 1);
      rd_en = 1; rd_addr = 6'd2;
      step();
      idle_inputs();
      check("inrange_small_pot", s_rd_potential, 32'h3F800000);
      check("inrange_small_spk", 32'(s_rd_spiked), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
